// File: rtl/data_sram_if.sv
// data_sram_if: request/response bundle of the data SRAM port.
interface data_sram_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output en, wen, addr, wdata, input rdata);
    modport slave  (input en, wen, addr, wdata, output rdata);
endinterface

// File: rtl/data_sram_responder.sv
// data_sram_responder: word RAM plus TIMER/LED/NUM registers behind a 1-cycle data SRAM port.
module data_sram_responder #(
    parameter int          ADDR_W    = 14,
    parameter logic [15:0] MMIO_BASE = 16'hBFAF
) (
    input  logic        clk,
    input  logic        resetn,
    data_sram_if.slave  bus,
    output logic [15:0] led,
    output logic [31:0] timer
);
    localparam logic [13:0] OFF_TIMER = 14'(16'hE000 >> 2);
    localparam logic [13:0] OFF_LED   = 14'(16'hF000 >> 2);
    localparam logic [13:0] OFF_NUM   = 14'(16'hF010 >> 2);

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] rdata_q, rdata_d, timer_q, timer_d, num_q, num_d, rd_word;
    logic [15:0] led_q, led_d;
    logic [ADDR_W-1:0] idx;
    logic is_mmio, rd, wr, hit_timer, hit_led, hit_num, unused_ok;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i+:8] = be[i] ? new_v[8*i+:8] : old_v[8*i+:8];
        return r;
    endfunction

    assign unused_ok = ^bus.addr[1:0];

    always_comb begin
        is_mmio   = bus.addr[31:16] == MMIO_BASE;
        idx       = bus.addr[ADDR_W+1:2];
        rd        = bus.en && bus.wen == 4'b0000;
        wr        = bus.en && bus.wen != 4'b0000;
        hit_timer = is_mmio && bus.addr[15:2] == OFF_TIMER;
        hit_led   = is_mmio && bus.addr[15:2] == OFF_LED;
        hit_num   = is_mmio && bus.addr[15:2] == OFF_NUM;
        rd_word   = !is_mmio ? mem[idx] :
                    hit_timer ? timer_q :
                    hit_led   ? {16'h0, led_q} :
                    hit_num   ? num_q : 32'h0;
        rdata_d   = rd ? rd_word : rdata_q;
        // a timer write replaces this cycle's increment
        timer_d   = (wr && hit_timer) ? merge(timer_q, bus.wdata, bus.wen) : timer_q + 32'd1;
        num_d     = (wr && hit_num) ? merge(num_q, bus.wdata, bus.wen) : num_q;
        led_d     = (wr && hit_led) ? {bus.wen[1] ? bus.wdata[15:8] : led_q[15:8],
                                       bus.wen[0] ? bus.wdata[7:0]  : led_q[7:0]} : led_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= 32'h0;
            timer_q <= 32'h0;
            num_q   <= 32'h0;
            led_q   <= 16'h0;
        end else begin
            rdata_q <= rdata_d;
            timer_q <= timer_d;
            num_q   <= num_d;
            led_q   <= led_d;
        end
    end

    // RAM keeps its contents through reset; writes are blocked while held
    always_ff @(posedge clk) begin
        if (resetn && wr && !is_mmio)
            for (int i = 0; i < 4; i++)
                if (bus.wen[i]) mem[idx][8*i+:8] <= bus.wdata[8*i+:8];
    end

    assign bus.rdata = rdata_q;
    assign led       = led_q;
    assign timer     = timer_q;
endmodule
